// File: rtl/sp_ram_ctrl.sv
// rtl/sp_ram_ctrl.sv - requester-side controller for a 1024x16 single-port block RAM
// Clears the RAM after reset, then issues in-order read/write requests and buffers read data.
module sp_ram_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int RSP_DEPTH = 4,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_busy,
  output logic              ram_ce,
  output logic              ram_wre,
  output logic              ram_oce,
  output logic              ram_reset,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              a_rd;
  logic              b_rd;
  logic [CW-1:0]     occ;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];

  logic accept;
  logic read_accept;
  logic pop;

  // occ counts every read not yet popped, so a push can never find the FIFO full
  assign req_ready   = (state == RUN) && (occ < DEPTH_C);
  assign accept      = req_valid & req_ready;
  assign read_accept = accept & ~req_we;
  assign rsp_valid   = (cnt != '0);
  assign pop         = rsp_valid & rsp_ready;
  assign rsp_rdata   = rsp_valid ? fifo_mem[rd_ptr] : '0;
  assign init_busy   = (state == CLEAR);
  assign ram_oce     = 1'b1;
  assign ram_reset   = reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_cnt <= '0;
      ram_ce  <= 1'b0;
      ram_wre <= 1'b0;
      ram_ad  <= '0;
      ram_din <= '0;
      a_rd    <= 1'b0;
      b_rd    <= 1'b0;
      occ     <= '0;
      cnt     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      ram_ce  <= 1'b0;
      ram_wre <= 1'b0;
      a_rd    <= 1'b0;
      b_rd    <= a_rd;
      if (state == CLEAR) begin
        ram_ce  <= 1'b1;
        ram_wre <= 1'b1;
        ram_ad  <= clr_cnt;
        ram_din <= CLEAR_VALUE;
        clr_cnt <= clr_cnt + ADDR_W'(1);
        if (clr_cnt == '1) state <= RUN;
      end else if (accept) begin
        ram_ce  <= 1'b1;
        ram_wre <= req_we;
        ram_ad  <= req_addr;
        ram_din <= req_wdata;
        a_rd    <= ~req_we;
      end

      case ({read_accept, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase

      // b_rd marks the cycle in which ram_dout carries the word read by stage A
      case ({b_rd, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (b_rd) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && b_rd) fifo_mem[wr_ptr] <= ram_dout;
  end

endmodule
